if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: the producer feeding the IF/ID pipeline register.

---
 rtl/if_fetch_unit_if.sv | 35 +++
 rtl/if_fetch_unit.sv | 73 +++++++
 tb/tb_if_fetch_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Bus between the instruction-fetch stage and its controller/IF-ID consumer.
// Signal names mirror the fetch-unit pin list so the mapping stays one-to-one.
interface if_fetch_unit_if #(
    parameter int INST_SZ   = 32,
    parameter int MEM_DEPTH = 256
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    logic               i_run;
    logic               i_step;
    logic               i_pc_write;
    logic               i_jump;
    logic [INST_SZ-1:0] i_jump_addr;
    logic               i_load_en;
    logic [ADDR_W-1:0]  i_load_addr;
    logic [INST_SZ-1:0] i_load_data;
    logic [INST_SZ-1:0] o_instruction;
    logic [INST_SZ-1:0] o_npc;
    logic [INST_SZ-1:0] o_bds;
    logic               o_if_id_enable;
    logic [INST_SZ-1:0] o_pc;
    logic               o_halted;

    modport master (
        output i_run, i_step, i_pc_write, i_jump, i_jump_addr,
               i_load_en, i_load_addr, i_load_data,
        input  o_instruction, o_npc, o_bds, o_if_id_enable, o_pc, o_halted
    );

    modport slave (
        input  i_run, i_step, i_pc_write, i_jump, i_jump_addr,
               i_load_en, i_load_addr, i_load_data,
        output o_instruction, o_npc, o_bds, o_if_id_enable, o_pc, o_halted
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, loader-written instruction memory and
// IDLE/RUN/HALTED control feeding the IF/ID pipeline register.
module if_fetch_unit #(
    parameter int                 INST_SZ     = 32,
    parameter int                 MEM_DEPTH   = 256,
    parameter logic [INST_SZ-1:0] HALT_OPCODE = 32'hFFFF_FFFF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    if_fetch_unit_if.slave bus
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t             state_q, state_d;
    logic [INST_SZ-1:0] pc_q, pc_d;
    logic [INST_SZ-1:0] mem [MEM_DEPTH];
    logic [INST_SZ-1:0] word;
    logic [INST_SZ-1:0] pc_plus4, pc_plus8;
    logic               fetch;
    logic               is_halt;

    // Upper PC bits and the byte offset are dropped, so addresses wrap the memory.
    assign word     = mem[pc_q[ADDR_W+1:2]];
    assign is_halt  = (word == HALT_OPCODE);
    assign pc_plus4 = pc_q + INST_SZ'(4);
    assign pc_plus8 = pc_q + INST_SZ'(8);

    // Memory contents survive reset; the loader is locked out while running.
    always_ff @(posedge i_clk) begin
        if (bus.i_load_en && state_q != RUN)
            mem[bus.i_load_addr] <= bus.i_load_data;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        fetch   = 1'b0;
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (bus.i_run)       state_d = RUN;
                else if (bus.i_step) fetch   = 1'b1;
            end
            RUN:     fetch = 1'b1;
            default: ;
        endcase
        // Stall beats jump beats HALT; a HALT on a jumped-over path is wrong-path.
        if (fetch && bus.i_pc_write) begin
            if (bus.i_jump)   pc_d    = bus.i_jump_addr;
            else if (is_halt) state_d = HALTED;
            else              pc_d    = pc_plus4;
        end
    end

    // Outputs are forced low while reset is held so no partial IF/ID write escapes.
    assign bus.o_instruction  = (i_reset && fetch) ? word : '0;
    assign bus.o_if_id_enable = i_reset && fetch && bus.i_pc_write;
    assign bus.o_npc          = i_reset ? pc_plus4 : '0;
    assign bus.o_bds          = i_reset ? pc_plus8 : '0;
    assign bus.o_pc           = i_reset ? pc_q : '0;
    assign bus.o_halted       = i_reset && (state_q == HALTED);
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus pushes expected IF/ID words,
// a negedge monitor pops and compares whenever the IF/ID enable is high.
module tb_if_fetch_unit;
    localparam logic [31:0] A    = 32'h1111_1111;
    localparam logic [31:0] B    = 32'h2222_2222;
    localparam logic [31:0] C    = 32'h3C3C_3C3C;
    localparam logic [31:0] J    = 32'h1616_1616;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] W5   = 32'h5555_5555;
    localparam logic [31:0] W6   = 32'h6666_6666;
    localparam logic [31:0] W3   = 32'h3333_3333;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
        logic [31:0] bds;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    if_fetch_unit_if #(.INST_SZ(32), .MEM_DEPTH(256)) bus ();

    if_fetch_unit #(.INST_SZ(32), .MEM_DEPTH(256), .HALT_OPCODE(32'hFFFF_FFFF)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] n, input logic [31:0] b);
        exp_t e;
        e.instr = i; e.npc = n; e.bds = b;
        sb.push_back(e);
    endtask

    // Monitor: any enabled IF/ID write must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.o_if_id_enable === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ifid_write: got instr %h pc %h want no write",
                         bus.o_instruction, bus.o_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ifid_instr", bus.o_instruction, e.instr);
                chk("ifid_npc",   bus.o_npc,         e.npc);
                chk("ifid_bds",   bus.o_bds,         e.bds);
            end
        end
    end

    initial begin
        logic [7:0]  la [7];
        logic [31:0] ld [7];
        la = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd16, 8'd17};
        ld = '{A, B, C, HALT, W5, J, HALT};

        rst_n = 1'b0;
        bus.i_run = 0; bus.i_step = 0; bus.i_pc_write = 1; bus.i_jump = 0;
        bus.i_jump_addr = '0; bus.i_load_en = 0; bus.i_load_addr = '0; bus.i_load_data = '0;

        @(negedge clk);
        chk("rst_instr",  bus.o_instruction, 32'h0);
        chk("rst_npc",    bus.o_npc, 32'h0);
        chk("rst_bds",    bus.o_bds, 32'h0);
        chk("rst_pc",     bus.o_pc, 32'h0);
        chk("rst_enable", 32'(bus.o_if_id_enable), 32'h0);
        chk("rst_halted", 32'(bus.o_halted), 32'h0);
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_npc",   bus.o_npc, 32'h4);
        chk("idle_instr", bus.o_instruction, 32'h0);

        for (int k = 0; k < 7; k++) begin
            tick(); bus.i_load_en = 1; bus.i_load_addr = la[k]; bus.i_load_data = ld[k];
        end
        tick(); bus.i_load_en = 0;

        // Run 1: A, B, stall at 8, C, HALT at 12; loader write during RUN dropped.
        tick(); bus.i_run = 1;
        tick(); push(A, 32'd4, 32'd8);
        tick(); push(B, 32'd8, 32'd12);
        bus.i_load_en = 1; bus.i_load_addr = 8'd5; bus.i_load_data = 32'hDEAD_BEEF;
        tick(); bus.i_load_en = 0; bus.i_pc_write = 0;
        @(negedge clk); chk("stall1_pc", bus.o_pc, 32'd8);
        tick();
        @(negedge clk); chk("stall2_pc", bus.o_pc, 32'd8);
        chk("stall2_enable", 32'(bus.o_if_id_enable), 32'h0);
        tick(); bus.i_pc_write = 1; push(C, 32'd12, 32'd16);
        tick(); push(HALT, 32'd16, 32'd20);
        tick();
        @(negedge clk);
        chk("halt_flag",  32'(bus.o_halted), 32'h1);
        chk("halt_pc",    bus.o_pc, 32'd12);
        chk("halt_instr", bus.o_instruction, 32'h0);
        tick();
        @(negedge clk); chk("halt_pc_hold", bus.o_pc, 32'd12);

        // Run 2: jump, jump-over-HALT, stall-beats-jump, reset mid-run.
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        tick(); push(A, 32'd4, 32'd8);
        tick(); bus.i_jump = 1; bus.i_jump_addr = 32'h40; push(B, 32'd8, 32'd12);
        tick(); bus.i_jump = 0; push(J, 32'h44, 32'h48);
        tick(); bus.i_jump = 1; bus.i_jump_addr = 32'h0; push(HALT, 32'h48, 32'h4C);
        tick(); bus.i_jump = 0; push(A, 32'd4, 32'd8);
        @(negedge clk);
        chk("jump_halt_not_halted", 32'(bus.o_halted), 32'h0);
        chk("jump_halt_pc", bus.o_pc, 32'h0);
        tick(); bus.i_pc_write = 0; bus.i_jump = 1; bus.i_jump_addr = 32'h80;
        tick(); bus.i_pc_write = 1; bus.i_jump = 0; push(B, 32'd8, 32'd12);
        @(negedge clk); chk("stall_jump_pc", bus.o_pc, 32'd4);
        tick(); rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_rst_pc",    bus.o_pc, 32'h0);
        chk("midrun_rst_instr", bus.o_instruction, 32'h0);
        chk("midrun_rst_npc",   bus.o_npc, 32'h0);
        chk("midrun_rst_bds",   bus.o_bds, 32'h0);
        chk("midrun_rst_en",    32'(bus.o_if_id_enable), 32'h0);
        tick(); bus.i_run = 0; rst_n = 1'b1;

        // Run 3: single-step path, load+step, HALTED load, wrap.
        tick(); bus.i_step = 1; push(A, 32'd4, 32'd8);
        tick(); bus.i_step = 0;
        tick();
        @(negedge clk);
        chk("step_idle_npc",   bus.o_npc, 32'd8);
        chk("step_idle_instr", bus.o_instruction, 32'h0);
        tick(); bus.i_step = 1; push(B, 32'd8, 32'd12);
        tick(); bus.i_step = 0;
        tick(); bus.i_step = 1; push(C, 32'd12, 32'd16);
        tick(); bus.i_step = 0;
        @(negedge clk); chk("step3_pc", bus.o_pc, 32'd12);
        tick(); bus.i_step = 1; push(HALT, 32'd16, 32'd20);
        bus.i_load_en = 1; bus.i_load_addr = 8'd3; bus.i_load_data = W3;
        tick(); bus.i_step = 0; bus.i_load_en = 0;
        @(negedge clk); chk("step_halt_flag", 32'(bus.o_halted), 32'h1);
        tick(); bus.i_load_en = 1; bus.i_load_addr = 8'd6; bus.i_load_data = W6;
        tick(); bus.i_load_en = 0;
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        tick(); bus.i_step = 1; bus.i_jump = 1; bus.i_jump_addr = 32'd20; push(A, 32'd4, 32'd8);
        tick(); bus.i_step = 0; bus.i_jump = 0;
        tick(); bus.i_step = 1; push(W5, 32'd24, 32'd28);
        tick(); bus.i_step = 0;
        tick(); bus.i_step = 1; bus.i_jump = 1; bus.i_jump_addr = 32'd12; push(W6, 32'd28, 32'd32);
        tick(); bus.i_step = 0; bus.i_jump = 0;
        tick(); bus.i_step = 1; bus.i_jump = 1; bus.i_jump_addr = 32'h400; push(W3, 32'd16, 32'd20);
        tick(); bus.i_step = 0; bus.i_jump = 0;
        tick(); bus.i_step = 1; push(A, 32'h404, 32'h408);
        tick(); bus.i_step = 0;
        @(negedge clk); chk("wrap_pc", bus.o_pc, 32'h404);

        tick(); tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
